// File: rtl/syn_fifo_flex_module_pkg.sv
// Shared definitions for the flexible synchronous FIFO: read-mode encodings
// and a constant log2 helper used to size pointers and counters.
package syn_fifo_flex_module_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Ceiling log2, usable in parameter and port-width expressions.
    function automatic int fifo_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port storage with one write port and one registered read port.
// The read register doubles as the FWFT head register in the top level, so it
// carries an async reset to give a defined o_rdata out of reset.
module syn_fifo_ram
    import syn_fifo_flex_module_pkg::*;
#(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_DEPTH = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  wr_en,
    input  logic [fifo_clog2(P_ADDR_DEPTH)-1:0]   wr_addr,
    input  logic [P_DATA_WIDTH-1:0]               wr_data,
    input  logic                                  rd_en,
    input  logic [fifo_clog2(P_ADDR_DEPTH)-1:0]   rd_addr,
    output logic [P_DATA_WIDTH-1:0]               rd_data
);

    logic [P_DATA_WIDTH-1:0] mem [P_ADDR_DEPTH];

    // Storage array is written on accepted writes only and is never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; holds its last value when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/syn_fifo_flex_module.sv
// Synchronous FIFO with standard or first-word-fall-through read mode,
// occupancy count, almost flags and one-cycle overflow/underflow pulses.
module syn_fifo_flex_module
    import syn_fifo_flex_module_pkg::*;
#(
    parameter int P_DATA_WIDTH    = 8,
    parameter int P_ADDR_DEPTH    = 16,
    parameter int P_FWFT          = 0,
    parameter int P_AFULL_THRESH  = 12,
    parameter int P_AEMPTY_THRESH = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_wr_en,
    input  logic [P_DATA_WIDTH-1:0]             i_wdata,
    output logic                                o_wfull,
    output logic                                o_almost_full,
    input  logic                                i_rd_en,
    output logic [P_DATA_WIDTH-1:0]             o_rdata,
    output logic                                o_rvalid,
    output logic                                o_rempty,
    output logic                                o_almost_empty,
    output logic [fifo_clog2(P_ADDR_DEPTH):0]   o_data_cnt,
    output logic                                o_overflow,
    output logic                                o_underflow
);

    localparam int ADDR_W = fifo_clog2(P_ADDR_DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam bit FWFT_MODE = (P_FWFT == FIFO_MODE_FWFT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH  = CNT_W'(P_ADDR_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL  = CNT_W'(P_AFULL_THRESH);
    localparam logic [CNT_W-1:0] CNT_AEMPTY = CNT_W'(P_AEMPTY_THRESH);

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] ram_cnt;
    logic             wr_accept;
    logic             rd_accept;
    logic             ram_rd;
    logic             head_valid;
    logic             head_valid_next;
    logic             rempty_next;
    logic             rvalid_std;
    logic [P_DATA_WIDTH-1:0] ram_rdata;

    assign wr_accept = i_wr_en && !o_wfull;
    assign rd_accept = i_rd_en && !o_rempty;

    // Words still sitting in the RAM (in FWFT mode the head register is extra).
    assign ram_cnt = wr_ptr - rd_ptr;

    // Next occupancy: +1 on write only, -1 on read only, unchanged otherwise.
    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    // RAM read issue and empty tracking. In FWFT mode the RAM read register is
    // the head register: refill it whenever it is empty or being popped.
    always_comb begin
        ram_rd          = 1'b0;
        head_valid_next = 1'b0;
        rempty_next     = 1'b1;
        if (FWFT_MODE) begin
            ram_rd          = (ram_cnt != '0) && (!head_valid || rd_accept);
            head_valid_next = ram_rd || (head_valid && !rd_accept);
            rempty_next     = !head_valid_next;
        end else begin
            ram_rd          = rd_accept;
            rempty_next     = (count_next == '0);
        end
    end

    // Pointer, count and registered flag state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            head_valid     <= 1'b0;
            rvalid_std     <= 1'b0;
            o_wfull        <= 1'b0;
            o_almost_full  <= 1'b0;
            o_rempty       <= 1'b1;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
            count          <= count_next;
            head_valid     <= head_valid_next;
            rvalid_std     <= rd_accept;
            o_wfull        <= (count_next == CNT_DEPTH);
            o_almost_full  <= (count_next >= CNT_AFULL);
            o_rempty       <= rempty_next;
            o_almost_empty <= (count_next <= CNT_AEMPTY);
            o_overflow     <= i_wr_en && o_wfull;
            o_underflow    <= i_rd_en && o_rempty;
        end
    end

    syn_fifo_ram #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_DEPTH (P_ADDR_DEPTH)
    ) u_ram (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (i_wdata),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (ram_rdata)
    );

    assign o_rdata    = ram_rdata;
    assign o_rvalid   = FWFT_MODE ? head_valid : rvalid_std;
    assign o_data_cnt = count;

endmodule
